// File: rtl/exec_alu_pip0.sv
// exec_alu_pip0: execute stage for pipe 0.
// E1 latches one issued micro-op per cycle. Single-cycle ALU ops produce a
// result at the next edge. MUL runs a 32-iteration shift-add loop while
// holding E1 and stalling issue. E2 registers drive every result output.
module exec_alu_pip0 #(
  parameter int                   W_PD_UOPS  = 6,
  parameter int                   W_PD_DATA  = 32,
  parameter int                   W_PA_REG   = 5,
  parameter int                   W_AA_INSTR = 32,
  parameter int                   W_MCNT     = 5,
  parameter logic [W_PD_UOPS-1:0] unused_op  = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
  input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
  input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
  input  logic [W_PA_REG-1:0]   DFI_PA_rd,
  input  logic                  CFI_PC_clear,
  output logic [W_PD_DATA-1:0]  DFO_PD_res,
  output logic [W_PA_REG-1:0]   DFO_PA_rd,
  output logic                  DFO_PV_res,
  output logic [W_AA_INSTR-1:0] DFO_AA_pc,
  output logic                  CFO_PC_busy,
  output logic                  CFO_PC_ill
);

  localparam int                   W_SH   = $clog2(W_PD_DATA);
  localparam logic [W_PD_UOPS-1:0] OP_MUL = W_PD_UOPS'(6'b011000);
  localparam logic [2:0]           GRP_RR = 3'b000;
  localparam logic [2:0]           GRP_RI = 3'b010;
  localparam logic [W_MCNT-1:0]    CNT_LAST = {W_MCNT{1'b1}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Single-cycle ALU; SLT compares as two's-complement, shifts use B's low bits
  function automatic logic [W_PD_DATA-1:0] alu_calc(
    input logic [2:0]           op,
    input logic [W_PD_DATA-1:0] a,
    input logic [W_PD_DATA-1:0] b
  );
    logic signed [W_PD_DATA-1:0] sa;
    logic signed [W_PD_DATA-1:0] sb;
    logic [W_SH-1:0]             sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[W_SH-1:0];
    case (op)
      3'd0:    alu_calc = a + b;
      3'd1:    alu_calc = a - b;
      3'd2:    alu_calc = a & b;
      3'd3:    alu_calc = a | b;
      3'd4:    alu_calc = a ^ b;
      3'd5:    alu_calc = (sa < sb) ? W_PD_DATA'(1) : '0;
      3'd6:    alu_calc = a << sh;
      default: alu_calc = a >> sh;
    endcase
  endfunction

  // Reg-reg group, reg-imm group and the single MUL code are the defined uops
  function automatic logic uop_defined(input logic [W_PD_UOPS-1:0] u);
    logic [2:0] grp;
    grp = u[W_PD_UOPS-1 -: 3];
    uop_defined = (grp == GRP_RR) || (grp == GRP_RI) || (u == OP_MUL);
  endfunction

  // E1 issue latch
  logic                  r_vld_p1;
  logic [W_PD_UOPS-1:0]  r_uops_p1;
  logic [W_PD_DATA-1:0]  r_a_p1;
  logic [W_PD_DATA-1:0]  r_b_p1;
  logic [W_PA_REG-1:0]   r_rd_p1;
  logic [W_AA_INSTR-1:0] r_pc_p1;

  // E2 output register
  logic                  r_vld_p2;
  logic                  r_ill_p2;
  logic [W_PD_DATA-1:0]  r_res_p2;
  logic [W_PA_REG-1:0]   r_rd_p2;
  logic [W_AA_INSTR-1:0] r_pc_p2;

  // Iterative multiplier
  state_t                r_state;
  state_t                w_state_nxt;
  logic [W_MCNT-1:0]     r_cnt;
  logic [W_MCNT-1:0]     w_cnt_nxt;
  logic [W_PD_DATA-1:0]  r_acc;
  logic [W_PD_DATA-1:0]  r_mcand;
  logic [W_PD_DATA-1:0]  r_mplier;
  logic [W_PD_DATA-1:0]  w_acc_nxt;

  logic                  w_e1_def;
  logic                  w_e1_mul;
  logic                  w_e1_alu;
  logic                  w_e1_wr;
  logic                  w_mul_start;
  logic                  w_mul_last;
  logic                  w_busy;
  logic [W_PD_DATA-1:0]  w_alu_res;

  assign w_e1_def    = uop_defined(r_uops_p1);
  assign w_e1_mul    = r_vld_p1 && (r_uops_p1 == OP_MUL);
  assign w_e1_alu    = r_vld_p1 && w_e1_def && (r_uops_p1 != OP_MUL);
  assign w_e1_wr     = (r_rd_p1 != '0);
  assign w_mul_start = (r_state == S_IDLE) && w_e1_mul && !CFI_PC_clear;
  assign w_mul_last  = (r_state == S_RUN) && (r_cnt == CNT_LAST);
  // Busy drops in the final iteration so the next op overlaps the writeback
  assign w_busy      = w_e1_mul && !w_mul_last;
  assign w_alu_res   = alu_calc(r_uops_p1[2:0], r_a_p1, r_b_p1);
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign CFO_PC_busy = w_busy;
  assign CFO_PC_ill  = r_ill_p2;
  assign DFO_PV_res  = r_vld_p2;
  assign DFO_PD_res  = r_res_p2;
  assign DFO_PA_rd   = r_rd_p2;
  assign DFO_AA_pc   = r_pc_p2;

  // ---- stage E1: accept a new op when idle, hold while a MUL runs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_uops_p1 <= unused_op;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_rd_p1   <= '0;
      r_pc_p1   <= '0;
    end else if (CFI_PC_clear) begin
      r_vld_p1 <= 1'b0;
    end else if (!w_busy) begin
      r_vld_p1 <= (DFI_PD_uops != unused_op);
      if (DFI_PD_uops != unused_op) begin
        r_uops_p1 <= DFI_PD_uops;
        r_a_p1    <= DFI_PD_rs;
        r_b_p1    <= (DFI_PD_uops[W_PD_UOPS-1 -: 3] == GRP_RI) ? DFI_PD_imm : DFI_PD_rt;
        r_rd_p1   <= DFI_PA_rd;
        r_pc_p1   <= DFI_AA_pc;
      end
    end
  end

  // MUL state register and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // MUL next state; the entry edge performs iteration 0, so the counter
  // then names the iteration to perform at the coming edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (CFI_PC_clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_e1_mul) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = W_MCNT'(1);
          end
        end
        default: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + W_MCNT'(1);
          end
        end
      endcase
    end
  end

  // Shift-add datapath: multiplier shifts right, multiplicand left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_mul_start) begin
      r_acc    <= r_b_p1[0] ? r_a_p1 : '0;
      r_mcand  <= r_a_p1 << 1;
      r_mplier <= r_b_p1 >> 1;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // ---- stage E2: register ALU result or final product; rd 0 not broadcast ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_ill_p2 <= 1'b0;
      r_res_p2 <= '0;
      r_rd_p2  <= '0;
      r_pc_p2  <= '0;
    end else if (CFI_PC_clear) begin
      r_vld_p2 <= 1'b0;
      r_ill_p2 <= 1'b0;
    end else begin
      r_ill_p2 <= r_vld_p1 && !w_e1_def;
      r_vld_p2 <= 1'b0;
      if (w_e1_alu || w_mul_last) begin
        r_vld_p2 <= w_e1_wr;
        if (w_e1_wr) begin
          r_res_p2 <= w_e1_alu ? w_alu_res : w_acc_nxt;
          r_rd_p2  <= r_rd_p1;
          r_pc_p2  <= r_pc_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_alu_pip0.sv
// Testbench for exec_alu_pip0: scoreboard of expected broadcasts, one task
// per scenario.
module tb_exec_alu_pip0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  DFI_PD_uops;
  logic [31:0] DFI_PD_rs, DFI_PD_rt, DFI_PD_imm, DFI_AA_pc;
  logic [4:0]  DFI_PA_rd;
  logic        CFI_PC_clear;
  logic [31:0] DFO_PD_res, DFO_AA_pc;
  logic [4:0]  DFO_PA_rd;
  logic        DFO_PV_res, CFO_PC_busy, CFO_PC_ill;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  exec_alu_pip0 dut (
    .clk(clk), .rst_n(rst_n),
    .DFI_PD_uops(DFI_PD_uops), .DFI_PD_rs(DFI_PD_rs), .DFI_PD_rt(DFI_PD_rt),
    .DFI_PD_imm(DFI_PD_imm), .DFI_AA_pc(DFI_AA_pc), .DFI_PA_rd(DFI_PA_rd),
    .CFI_PC_clear(CFI_PC_clear),
    .DFO_PD_res(DFO_PD_res), .DFO_PA_rd(DFO_PA_rd), .DFO_PV_res(DFO_PV_res),
    .DFO_AA_pc(DFO_AA_pc), .CFO_PC_busy(CFO_PC_busy), .CFO_PC_ill(CFO_PC_ill)
  );

  // Reference model of the architectural result
  function automatic logic [31:0] model(input logic [5:0] u, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [31:0] imm);
    logic [31:0] b;
    logic [63:0] p;
    p = {32'd0, rs} * {32'd0, rt};
    if (u == 6'o30) return p[31:0];
    b = (u[5:3] == 3'b010) ? imm : rt;
    case (u[2:0])
      3'd0: return rs + b;
      3'd1: return rs - b;
      3'd2: return rs & b;
      3'd3: return rs | b;
      3'd4: return rs ^ b;
      3'd5: return ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return rs << b[4:0];
      default: return rs >> b[4:0];
    endcase
  endfunction

  task automatic drive(input logic [5:0] u, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    DFI_PD_uops = u; DFI_PD_rs = rs; DFI_PD_rt = rt;
    DFI_PD_imm = imm; DFI_AA_pc = pc; DFI_PA_rd = rd;
  endtask

  task automatic issue(input logic [5:0] u, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    drive(u, rs, rt, imm, pc, rd);
    sb.push_back({model(u, rs, rt, imm), rd, pc});
  endtask

  task automatic idle_in();
    DFI_PD_uops = 6'o77;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; CFI_PC_clear = 1'b0;
    drive(6'o77, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc, DFO_PV_res, CFO_PC_busy, CFO_PC_ill} !== '0) begin
      errors++;
      $display("FAIL reset_outs got res=%h rd=%h pc=%h pv=%b busy=%b ill=%b exp all 0",
               DFO_PD_res, DFO_PA_rd, DFO_AA_pc, DFO_PV_res, CFO_PC_busy, CFO_PC_ill);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_t e;
    issue(6'o00, 5, 7, 32'hdead, 32'h100, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) idle_in();
      checks++;
      if (CFO_PC_busy !== 1'b0) begin errors++; $display("FAIL add_busy k=%0d got=%b exp=0", k, CFO_PC_busy); end
      checks++;
      if (DFO_PV_res !== (k == 1)) begin errors++; $display("FAIL add_pv k=%0d got=%b exp=%b", k, DFO_PV_res, k == 1); end
      if (DFO_PV_res === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL add_sb got=%h exp=<empty>", DFO_PD_res); end
        else begin
          e = sb.pop_front();
          if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== e) begin
            errors++; $display("FAIL add_out got=%h/%0d/%h exp=%h/%0d/%h", DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
          end
        end
      end
    end
  endtask

  task automatic test_alu_b2b();
    localparam int N = 12;
    logic [5:0]  tu  [N] = '{6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o05, 6'o06, 6'o27, 6'o20, 6'o21, 6'o05, 6'o24};
    logic [31:0] trs [N] = '{10, 32'hf0f0, 32'hf0f0, 32'hff00, 32'hffffffff, 1, 1, 32'h80000000, 32'hffffffff, 0, 5, 32'h1234};
    logic [31:0] trt [N] = '{3, 32'h0ff0, 32'h0f0f, 32'h0ff0, 1, 32'hffffffff, 31, 99, 77, 77, 5, 88};
    logic [31:0] tim [N] = '{55, 55, 55, 55, 55, 55, 55, 4, 2, 1, 55, 32'hffff};
    exp_t e;
    for (int i = 0; i < N + 2; i++) begin
      if (i >= 2) begin
        checks++;
        if (DFO_PV_res !== 1'b1) begin errors++; $display("FAIL b2b_pv i=%0d got=%b exp=1", i - 2, DFO_PV_res); end
        if (DFO_PV_res === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb got=%h exp=<empty>", DFO_PD_res); end
          else begin
            e = sb.pop_front();
            if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== e) begin
              errors++; $display("FAIL b2b_out i=%0d got=%h/%0d/%h exp=%h/%0d/%h", i - 2, DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
            end
          end
        end
      end
      if (i < N) issue(tu[i], trs[i], trt[i], tim[i], 32'h300 + 32'(4 * i), 5'(i + 1));
      else idle_in();
      @(negedge clk);
    end
    // leave the bench at the negedge following the last result
  endtask

  task automatic test_mul(input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    issue(6'o30, rs, rt, 32'h5555, 32'h200, 5);
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      if (c == 0) issue(6'o00, 1, 2, 0, 32'h204, 6);
      if (c == 32) idle_in();
      checks++;
      if (CFO_PC_busy !== (c <= 30)) begin errors++; $display("FAIL mul_busy c=%0d got=%b exp=%b", c, CFO_PC_busy, c <= 30); end
      checks++;
      if (DFO_PV_res !== (c >= 32)) begin errors++; $display("FAIL mul_pv c=%0d got=%b exp=%b", c, DFO_PV_res, c >= 32); end
      if (DFO_PV_res === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL mul_sb got=%h exp=<empty>", DFO_PD_res); end
        else begin
          e = sb.pop_front();
          if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== e) begin
            errors++; $display("FAIL mul_out c=%0d got=%h/%0d/%h exp=%h/%0d/%h", c, DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
          end
        end
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    drive(6'o30, 7, 9, 0, 32'h3f0, 8);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 0) idle_in();
      if (c == 9) CFI_PC_clear = 1'b1;
      if (c == 10) begin CFI_PC_clear = 1'b0; issue(6'o00, 3, 4, 0, 32'h400, 7); end
      if (c == 11) idle_in();
      checks++;
      if (CFO_PC_busy !== (c <= 9)) begin errors++; $display("FAIL clr_busy c=%0d got=%b exp=%b", c, CFO_PC_busy, c <= 9); end
      checks++;
      if (DFO_PV_res !== (c == 12)) begin errors++; $display("FAIL clr_pv c=%0d got=%b exp=%b", c, DFO_PV_res, c == 12); end
      if (DFO_PV_res === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL clr_sb got=%h exp=<empty>", DFO_PD_res); end
        else begin
          e = sb.pop_front();
          if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== e) begin
            errors++; $display("FAIL clr_out got=%h/%0d/%h exp=%h/%0d/%h", DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
          end
        end
      end
    end
    // an op presented on the clearing edge is dropped
    drive(6'o00, 1, 1, 0, 32'h410, 12);
    CFI_PC_clear = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      CFI_PC_clear = 1'b0; idle_in();
      checks++;
      if (DFO_PV_res !== 1'b0) begin errors++; $display("FAIL clr_drop c=%0d got=%b exp=0", c, DFO_PV_res); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue(6'o00, 32'h11, 32'h22, 0, 32'h500, 9);
    @(negedge clk);
    drive(6'o30, 2, 3, 0, 32'h504, 10);
    @(negedge clk);
    idle_in();
    checks++;
    e = sb.pop_front();
    if ({DFO_PV_res, DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== {1'b1, e}) begin
      errors++; $display("FAIL rstm_pre got=%b/%h/%0d/%h exp=1/%h/%0d/%h", DFO_PV_res, DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc, DFO_PV_res, CFO_PC_busy, CFO_PC_ill} !== '0) begin
      errors++; $display("FAIL rstm_mul got res=%h rd=%h pc=%h pv=%b busy=%b ill=%b exp all 0",
                         DFO_PD_res, DFO_PA_rd, DFO_AA_pc, DFO_PV_res, CFO_PC_busy, CFO_PC_ill);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'o00, 32'h20, 32'h3, 0, 32'h520, 11);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) idle_in();
      checks++;
      if (CFO_PC_busy !== 1'b0) begin errors++; $display("FAIL rstm_busy c=%0d got=%b exp=0", c, CFO_PC_busy); end
      checks++;
      if (DFO_PV_res !== (c == 1)) begin errors++; $display("FAIL rstm_pv c=%0d got=%b exp=%b", c, DFO_PV_res, c == 1); end
      if (DFO_PV_res === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rstm_sb got=%h exp=<empty>", DFO_PD_res); end
        else begin
          e = sb.pop_front();
          if ({DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== e) begin
            errors++; $display("FAIL rstm_out got=%h/%0d/%h exp=%h/%0d/%h", DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
          end
        end
      end
    end
    // reset while an ALU op sits in E1
    drive(6'o00, 32'h9, 32'h9, 0, 32'h540, 13);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    idle_in();
    checks++;
    if ({DFO_PD_res, DFO_PV_res, CFO_PC_busy} !== '0) begin
      errors++; $display("FAIL rstm_alu got res=%h pv=%b busy=%b exp all 0", DFO_PD_res, DFO_PV_res, CFO_PC_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (DFO_PV_res !== 1'b0) begin errors++; $display("FAIL rstm_alu_pv c=%0d got=%b exp=0", c, DFO_PV_res); end
    end
  endtask

  task automatic test_rd0_ill();
    exp_t e;
    logic [5:0] bad [2] = '{6'o50, 6'o31};
    issue(6'o00, 32'h40, 32'h2, 0, 32'h600, 4);
    @(negedge clk);
    drive(6'o00, 100, 1, 0, 32'h604, 0);
    @(negedge clk);
    idle_in();
    checks++;
    e = sb.pop_front();
    if ({DFO_PV_res, DFO_PD_res, DFO_PA_rd, DFO_AA_pc} !== {1'b1, e}) begin
      errors++; $display("FAIL rd0_pre got=%b/%h/%0d/%h exp=1/%h/%0d/%h", DFO_PV_res, DFO_PD_res, DFO_PA_rd, DFO_AA_pc, e.res, e.rd, e.pc);
    end
    @(negedge clk);
    checks++;
    if ({DFO_PV_res, DFO_PD_res, DFO_PA_rd, DFO_AA_pc, CFO_PC_ill} !== {1'b0, e, 1'b0}) begin
      errors++; $display("FAIL rd0_hold got=%b/%h/%0d/%h ill=%b exp=0/%h/%0d/%h ill=0",
                         DFO_PV_res, DFO_PD_res, DFO_PA_rd, DFO_AA_pc, CFO_PC_ill, e.res, e.rd, e.pc);
    end
    for (int j = 0; j < 2; j++) begin
      drive(bad[j], 1, 2, 3, 32'h700, 9);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (c == 0) idle_in();
        checks++;
        if (CFO_PC_ill !== (c == 1)) begin errors++; $display("FAIL ill_pulse u=%o c=%0d got=%b exp=%b", bad[j], c, CFO_PC_ill, c == 1); end
        checks++;
        if (DFO_PV_res !== 1'b0) begin errors++; $display("FAIL ill_pv u=%o c=%0d got=%b exp=0", bad[j], c, DFO_PV_res); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_alu_b2b();
    test_mul(32'h00010000, 32'h00030003);
    test_mul(32'hffffffff, 32'hffffffff);
    test_mul($urandom, $urandom);
    test_clear();
    test_reset_mid();
    test_rd0_ill();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
